// File: rtl/lc3b_control.sv
// Multicycle Moore control FSM for the LC-3b datapath (ADD, AND, NOT, LDR, STR, BR).
// Every strobe decodes from the state register; only instr_done also looks at inputs, in STR2 and BR.
module lc3b_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic       alumux_sel,
  output logic       regfilemux_sel,
  output logic [1:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH1    = 4'd0,
    S_FETCH2    = 4'd1,
    S_FETCH3    = 4'd2,
    S_DECODE    = 4'd3,
    S_ADD       = 4'd4,
    S_AND       = 4'd5,
    S_NOT       = 4'd6,
    S_CALC_ADDR = 4'd7,
    S_LDR1      = 4'd8,
    S_LDR2      = 4'd9,
    S_STR1      = 4'd10,
    S_STR2      = 4'd11,
    S_BR        = 4'd12,
    S_BR_TAKEN  = 4'd13
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = S_FETCH1;
    load_pc        = 1'b0;
    pcmux_sel      = 1'b0;
    storemux_sel   = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    alumux_sel     = 1'b0;
    regfilemux_sel = 1'b0;
    aluop          = 2'b00;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    instr_done     = 1'b0;

    case (state_q)
      S_FETCH1: begin
        load_mar   = 1'b1;
        marmux_sel = 1'b1;
        load_pc    = 1'b1;
        state_d    = S_FETCH2;
      end
      S_FETCH2: begin
        mem_read   = 1'b1;
        mdrmux_sel = 1'b1;
        load_mdr   = 1'b1;
        state_d    = mem_resp ? S_FETCH3 : S_FETCH2;
      end
      S_FETCH3: begin
        load_ir = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Unsupported opcodes fall back to FETCH1 silently as NOPs.
        case (opcode)
          4'b0001:         state_d = S_ADD;
          4'b0101:         state_d = S_AND;
          4'b1001:         state_d = S_NOT;
          4'b0110, 4'b0111: state_d = S_CALC_ADDR;
          4'b0000:         state_d = S_BR;
          default:         state_d = S_FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        load_regfile = 1'b1;
        load_cc      = 1'b1;
        instr_done   = 1'b1;
        aluop        = (state_q == S_ADD) ? 2'b00 :
                       (state_q == S_AND) ? 2'b01 : 2'b10;
        state_d      = S_FETCH1;
      end
      S_CALC_ADDR: begin
        alumux_sel = 1'b1;
        load_mar   = 1'b1;
        state_d    = (opcode == 4'b0110) ? S_LDR1 : S_STR1;
      end
      S_LDR1: begin
        mem_read   = 1'b1;
        mdrmux_sel = 1'b1;
        load_mdr   = 1'b1;
        state_d    = mem_resp ? S_LDR2 : S_LDR1;
      end
      S_LDR2: begin
        load_regfile   = 1'b1;
        regfilemux_sel = 1'b1;
        load_cc        = 1'b1;
        instr_done     = 1'b1;
        state_d        = S_FETCH1;
      end
      S_STR1: begin
        storemux_sel = 1'b1;
        aluop        = 2'b11;
        load_mdr     = 1'b1;
        state_d      = S_STR2;
      end
      S_STR2: begin
        mem_write  = 1'b1;
        instr_done = mem_resp;
        state_d    = mem_resp ? S_FETCH1 : S_STR2;
      end
      S_BR: begin
        instr_done = ~branch_enable;
        state_d    = branch_enable ? S_BR_TAKEN : S_FETCH1;
      end
      S_BR_TAKEN: begin
        load_pc    = 1'b1;
        pcmux_sel  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH1;
      end
      default: state_d = S_FETCH1;
    endcase
  end

endmodule
